// File: rtl/loopback_fifo_device.sv
// Byte loopback: RX handshake -> FIFO -> TX strobe, with pause and flush.
// Define LOOPBACK_LEVEL_EN to expose the fifo_level output port.
module loopback_fifo_device #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              pause_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_ready,
  output logic              rx_data_accept,
  input  logic              tx_busy,
  output logic              wren,
  output logic [DATA_W-1:0] tx_data
`ifdef LOOPBACK_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] fifo_level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  typedef enum logic {R_IDLE, R_ACK} rx_st_t;
  typedef enum logic {T_IDLE, T_STROBE} tx_st_t;

  rx_st_t rx_st;
  tx_st_t tx_st;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic full;
  logic empty;
  logic rx_go;
  logic tx_go;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);

  assign rx_go = (rx_st == R_IDLE) && rx_data_ready && !full
                 && pause_n && !flush;
  assign tx_go = (tx_st == T_IDLE) && !empty && !tx_busy
                 && pause_n && !flush;

  // Storage write; contents need no reset since count gates reads
  always_ff @(posedge sys_clk) begin
    if (rx_go) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers and occupancy; flush wins over any same-edge transfer
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rx_go) wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_go) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count
               + {{DEPTH_LOG2{1'b0}}, rx_go}
               - {{DEPTH_LOG2{1'b0}}, tx_go};
    end
  end

  // RX FSM: accept one word, then one recovery cycle
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_st          <= R_IDLE;
      rx_data_accept <= 1'b0;
    end else begin
      unique case (rx_st)
        R_IDLE: begin
          if (rx_go) begin
            rx_st          <= R_ACK;
            rx_data_accept <= 1'b1;
          end
        end
        R_ACK: begin
          rx_st          <= R_IDLE;
          rx_data_accept <= 1'b0;
        end
        default: begin
          rx_st          <= R_IDLE;
          rx_data_accept <= 1'b0;
        end
      endcase
    end
  end

  // TX FSM: strobe one word out, then one recovery cycle
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      tx_st   <= T_IDLE;
      wren    <= 1'b0;
      tx_data <= '0;
    end else begin
      unique case (tx_st)
        T_IDLE: begin
          if (tx_go) begin
            tx_st   <= T_STROBE;
            wren    <= 1'b1;
            tx_data <= mem[rd_ptr];
          end
        end
        T_STROBE: begin
          tx_st <= T_IDLE;
          wren  <= 1'b0;
        end
        default: begin
          tx_st <= T_IDLE;
          wren  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOOPBACK_LEVEL_EN
  assign fifo_level = count;
`endif

endmodule
